// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exec_sequencer
//  Description : Execute-stage controller. Accepts one decoded instruction at
//                a time from decode (valid/ready), holds execute_enable high
//                for the op's latency (1 cycle for base ops, MUL_LATENCY or
//                DIV_LATENCY for M-extension ops), then presents the result to
//                the memory stage (valid/ready). Registers jump redirects or
//                misaligned-target exceptions, and counts output stalls.
//
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                in_valid/in_ready    - decode handshake
//                in_opcode/funct3/7   - fields used for latency selection
//                flush                - kill any in-flight op
//                execute_enable       - executor enable
//                ex_jump_signal/target- executor jump decision and target
//                out_valid/out_ready  - memory-stage handshake
//                redirect_valid/pc    - one-cycle fetch redirect
//                misaligned_exc       - one-cycle misaligned-target pulse
//                stall_cycles         - saturating back-pressure counter
//
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 33,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    output logic        in_ready,
    input  logic        flush,
    output logic        execute_enable,
    input  logic        ex_jump_signal,
    input  logic [63:0] ex_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        misaligned_exc,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter reload values are latency minus one: the counter reaching zero
    // marks the final execute cycle.
    localparam logic [CNT_W-1:0] c_mul_m1 = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_div_m1 = CNT_W'(DIV_LATENCY - 1);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_redirect_valid;
    logic [63:0]        r_redirect_pc;
    logic               r_misaligned;
    logic [31:0]        r_stall;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_mext;
    logic [CNT_W-1:0]   w_lat_m1;
    logic               w_last_busy;
    logic               w_unused_funct3;

    // Only funct3[2] distinguishes MUL-class from DIV-class ops.
    assign w_unused_funct3 = &{1'b0, in_funct3[1:0]};

    // in_ready is a pure function of state and out_ready; flush only blocks
    // the acceptance itself so the handshake stays free of the kill path.
    assign w_in_ready = !reset &&
                        ((r_state == ST_IDLE) ||
                         ((r_state == ST_DONE) && out_ready));
    assign w_accept   = in_valid && w_in_ready && !flush;

    assign w_is_mext  = ((in_opcode == 7'b0110011) || (in_opcode == 7'b0111011)) &&
                        (in_funct7 == 7'b0000001);
    assign w_lat_m1   = !w_is_mext   ? '0       :
                        in_funct3[2] ? c_div_m1 : c_mul_m1;

    assign w_last_busy = (r_state == ST_BUSY) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        w_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_next = w_accept ? ST_BUSY : ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 64'd0;
            r_misaligned     <= 1'b0;
            r_stall          <= 32'd0;
        end else begin
            r_state          <= w_next;
            r_redirect_valid <= 1'b0;
            r_misaligned     <= 1'b0;

            if (w_accept) begin
                r_cnt <= w_lat_m1;
            end else if ((r_state == ST_BUSY) && (r_cnt != '0) && !flush) begin
                r_cnt <= r_cnt - c_one;
            end

            // Jump decision is only meaningful on the last execute cycle;
            // the resulting pulse lines up with the first DONE cycle.
            if (w_last_busy && !flush && ex_jump_signal) begin
                if (ex_target[1:0] == 2'b00) begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= ex_target;
                end else begin
                    r_misaligned     <= 1'b1;
                end
            end

            if ((r_state == ST_DONE) && !out_ready && (r_stall != 32'hFFFF_FFFF)) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign execute_enable = (r_state == ST_BUSY);
    assign out_valid      = (r_state == ST_DONE);
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign misaligned_exc = r_misaligned;
    assign stall_cycles   = r_stall;

endmodule
`default_nettype wire

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Controls the execute stage. Accepts one decoded instruction at a time from decode with a valid/ready handshake.
- Drives the executor's execute_enable for the op's latency: 1 cycle for base ops, a parameterised count for M-extension MUL/DIV ops.
- Presents the result to memory with a valid/ready handshake.
- Registers branch/jump redirects to fetch and counts back-pressure stalls.

Parameters:
- MUL_LATENCY, 3, execute cycles for M-ext funct3[2]=0 ops; must be >=1.
- DIV_LATENCY, 33, execute cycles for M-ext funct3[2]=1 ops; must be >=1.
- CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_LATENCY, DIV_LATENCY).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents an instruction; operands are held stable upstream while in_ready=0.
- in_opcode  input  7  opcode of presented instruction.
- in_funct3  input  3  funct3 of presented instruction.
- in_funct7  input  7  funct7 of presented instruction.
- in_ready  output  1  sequencer can accept (combinational from state/out_ready).
- flush  input  1  kill in-flight op (external redirect/exception).
- execute_enable  output  1  enable to the executor.
- ex_jump_signal  input  1  executor's jump decision (combinational, valid while execute_enable=1).
- ex_target  input  64  executor's jump target PC.
- out_valid  output  1  result ready for memory stage.
- out_ready  input  1  memory stage accepts result.
- redirect_valid  output  1  one-cycle pulse: fetch must jump.
- redirect_pc  output  64  jump target, valid with redirect_valid.
- misaligned_exc  output  1  one-cycle pulse: taken jump target with ex_target[1:0]!=0.
- stall_cycles  output  32  count of cycles with out_valid=1 and out_ready=0; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE and counter to 0.
  - execute_enable, out_valid, redirect_valid and misaligned_exc are 0; redirect_pc is 0; stall_cycles is 0.
  - in_ready is forced 0 while reset=1.
  - Reset mid-operation abandons the op with no redirect.
- Op classification at accept:
  - M-ext is (in_opcode==7'b0110011 or 7'b0111011) and in_funct7==7'b0000001.
  - M-ext with funct3[2]=0 gives latency L=MUL_LATENCY; M-ext with funct3[2]=1 gives L=DIV_LATENCY; everything else gives L=1.
- States:
  - IDLE:
    - in_ready=1. On in_valid & in_ready & !flush, go to BUSY with counter=L-1.
  - BUSY:
    - execute_enable=1, in_ready=0.
    - If counter!=0, decrement.
    - If counter==0, go to DONE and sample the jump decision:
      - ex_jump_signal=1 and ex_target[1:0]==0: redirect_valid=1 and redirect_pc=ex_target on the next cycle.
      - ex_jump_signal=1 and ex_target[1:0]!=0: misaligned_exc=1 instead; no redirect.
  - DONE:
    - out_valid=1, execute_enable=0; redirect pulses last exactly the first DONE cycle.
    - in_ready=out_ready.
    - On out_ready: if in_valid, accept back-to-back and go to BUSY with the new counter; else go to IDLE.
    - On !out_ready, hold DONE and increment stall_cycles (saturating).
- Latency:
  - Op accepted at edge N: execute_enable high for cycles N+1..N+L; out_valid first high at N+1+L.
  - Throughput is one op per L+1 cycles with out_ready held 1.
- flush:
  - Highest priority after reset. In any state, next state is IDLE; out_valid, execute_enable and pending redirect/exception are suppressed.
  - An in_valid in the same cycle is not accepted.
  - flush during the final BUSY cycle produces no redirect.
- redirect_pc holds its last value outside pulses.
- stall_cycles is never cleared except by reset.
- ex_jump_signal/ex_target are ignored outside the final BUSY cycle.

Test Plan:
- ADD (opcode 0110011, funct7 0) accepted at cycle 0, out_ready=1 -> execute_enable high cycle 1 only; out_valid high cycle 2; in_ready high cycle 2; no redirect.
- MUL (funct7 0000001, funct3 000), MUL_LATENCY=3 -> execute_enable cycles 1-3; out_valid cycle 4. DIV (funct3 100), DIV_LATENCY=33 -> out_valid at cycle 34.
- JAL with ex_jump_signal=1, ex_target=64'h8000_0040 -> redirect_valid pulse exactly 1 cycle, redirect_pc=64'h8000_0040, coincident with first out_valid cycle. Repeat with ex_target=64'h8000_0042 -> misaligned_exc pulse, redirect_valid stays 0.
- out_ready held 0 for 5 cycles in DONE -> stall_cycles increments by 5; out_valid stays 1; release out_ready with in_valid=1 -> back-to-back accept, next op's execute_enable the following cycle.
- DIV in BUSY, flush asserted at cycle 10 -> IDLE at cycle 11; out_valid never asserts; no redirect even with ex_jump_signal=1.
- reset asserted mid-DIV at cycle 5 -> cycle 6: all outputs 0, stall_cycles=0; in_ready=1 once reset deasserts.
